mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_load_align.sv | 42 ++++
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, funct3 access-size encodings and the FSM state
//               type for the memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    // Register-file geometry
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_DATA_WIDTH-1:0] REG_DATA_ZERO = '0;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ADDR_ZERO = '0;

    // Data-memory byte-enable width (32-bit data bus)
    localparam int DMEM_BE_WIDTH = 4;

    // funct3 access-size encodings
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Access FSM: IDLE waits for an op, REQ holds the request until ack
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Formats a raw 32-bit read word into the load result: selects
//               the addressed byte/halfword and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]                funct3_i,
    input  logic [1:0]                addr_lo_i,
    input  logic [31:0]               rdata_i,
    output logic [REG_DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the access size
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            MEM_B:   data_o = {{(REG_DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            MEM_BU:  data_o = {{(REG_DATA_WIDTH-8){1'b0}}, byte_sel};
            MEM_H:   data_o = {{(REG_DATA_WIDTH-16){half_sel[15]}}, half_sel};
            MEM_HU:  data_o = {{(REG_DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory-access stage. Issues loads/stores over a
//               req/ack handshake, stalls the front end while an access is
//               outstanding, formats load data and owns the MEM/WB register.
//               Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned
//               halfword/word accesses and flags them on mem_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 32
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [REG_DATA_WIDTH-1:0]  alu_result,
    input  logic [REG_DATA_WIDTH-1:0]  store_data,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr,
    input  logic                       ex_reg_write,
    input  logic                       ex_mem_read,
    input  logic                       ex_mem_write,
    input  logic [2:0]                 ex_funct3,
    output logic                       mem_stall,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]                dmem_wdata,
    output logic [DMEM_BE_WIDTH-1:0]   dmem_be,
    input  logic                       dmem_ack,
    input  logic [31:0]                dmem_rdata,
    output logic [REG_DATA_WIDTH-1:0]  wb_mem_data,
    output logic [REG_DATA_WIDTH-1:0]  wb_alu_data,
    output logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr,
    output logic                       wb_reg_write,
    output logic                       wb_mem_to_reg,
    output logic                       mem_misalign
);

    mem_state_t state_q, state_d;

    logic                      mem_op;
    logic                      misalign;
    logic                      issue;
    logic                      launch;
    logic                      wb_commit;
    logic                      mis_event;
    logic [1:0]                addr_lo;
    logic [DMEM_BE_WIDTH-1:0]  be_d;
    logic [31:0]               wdata_d;
    logic [REG_DATA_WIDTH-1:0] load_fmt;
    logic                      wb_reg_write_d;
    logic                      wb_mem_to_reg_d;

    logic                       dmem_req_q;
    logic                       dmem_we_q;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_q;
    logic [31:0]                dmem_wdata_q;
    logic [DMEM_BE_WIDTH-1:0]   dmem_be_q;
    logic [REG_DATA_WIDTH-1:0]  wb_mem_data_q;
    logic [REG_DATA_WIDTH-1:0]  wb_alu_data_q;
    logic [REG_ADDR_WIDTH-1:0]  wb_rd_addr_q;
    logic                       wb_reg_write_q;
    logic                       wb_mem_to_reg_q;

    assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
    assign addr_lo = alu_result[1:0];
    assign issue   = mem_op & ~misalign;

`ifdef MEM_MISALIGN_CHECK_EN
    logic mem_misalign_q;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0
    always_comb begin
        case (ex_funct3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase
    end

    // One-cycle flag accompanying the bubble of a suppressed access
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_misalign_q <= 1'b0;
        end else begin
            mem_misalign_q <= mis_event;
        end
    end

    assign mem_misalign = mem_misalign_q;
`else
    // Misaligned low bits are simply dropped by the lane logic
    assign misalign     = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on an issued access, return on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)    state_d = REQ;
            REQ:     if (dmem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stall, request launch, MEM/WB commit and misalign event
    always_comb begin
        mem_stall = 1'b0;
        launch    = 1'b0;
        wb_commit = 1'b0;
        mis_event = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    mem_stall = issue;
                    launch    = issue;
                    wb_commit = ~mem_op;
                    mis_event = mem_op & misalign;
                end
                REQ: begin
                    mem_stall = ~dmem_ack;
                    wb_commit = dmem_ack;
                end
                default: ;
            endcase
        end
    end

    // Byte enables and lane-replicated store data by access size
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_lo;
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_d = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .funct3_i  (ex_funct3),
        .addr_lo_i (addr_lo),
        .rdata_i   (dmem_rdata),
        .data_o    (load_fmt)
    );

    // A store never writes the register file; read+write counts as store
    assign wb_reg_write_d  = wb_commit & ex_valid & ex_reg_write & ~ex_mem_write;
    assign wb_mem_to_reg_d = wb_commit & mem_op & ex_mem_read & ~ex_mem_write;

    // Request registers: captured on launch, held until ack
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
        end else if (launch) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= ex_mem_write;
            dmem_addr_q  <= {alu_result[DMEM_ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata_q <= wdata_d;
            dmem_be_q    <= be_d;
        end else if ((state_q == REQ) && dmem_ack) begin
            dmem_req_q   <= 1'b0;
        end
    end

    // MEM/WB register: reloads every cycle, bubbles carry no write
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_mem_data_q   <= REG_DATA_ZERO;
            wb_alu_data_q   <= REG_DATA_ZERO;
            wb_rd_addr_q    <= REG_ADDR_ZERO;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
        end else begin
            wb_mem_data_q   <= load_fmt;
            wb_alu_data_q   <= alu_result;
            wb_rd_addr_q    <= ex_rd_addr;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign dmem_be       = dmem_be_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_alu_data   = wb_alu_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage: directed cases plus random
//               instruction stream against a behavioural reference model.
//               Honours MEM_MISALIGN_CHECK_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] alu_result, store_data;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] wb_mem_data, wb_alu_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write, wb_mem_to_reg, mem_misalign;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
        .store_data(store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_mem_data(wb_mem_data),
        .wb_alu_data(wb_alu_data), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .mem_misalign(mem_misalign)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] mem_data; logic [31:0] alu; logic [4:0] rd;
                     logic rw; logic m2r; logic mis; } wb_t;
    typedef struct { int delay; logic [31:0] rdata; } resp_t;

    req_t  req_q[$];
    wb_t   wb_q[$];
    resp_t resp_q[$];

    int errors = 0;
    int checks = 0;
    bit mon_en  = 0;
    bit resp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (rd >> (8 * a[1:0])) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                v = (rd >> (16 * a[1])) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic bit is_half(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    function automatic bit is_byte(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b100);
    endfunction

    // Drive one EX/MEM entry, push expectations, hold it until accepted
    task automatic issue(input bit v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                         input logic [2:0] f3, input int delay, input logic [31:0] rdata);
        bit   memop, mis, go;
        int   exp_stall, stalls;
        req_t r;
        wb_t  w;
        memop = v && (mr || mw);
        mis   = 0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (memop && is_half(f3) && alu[0]) mis = 1;
        if (memop && !is_half(f3) && !is_byte(f3) && (alu % 4 != 0) && f3 == 3'b010) mis = 1;
`endif
        go = memop && !mis;
        w.mem_data = 32'h0; w.alu = alu; w.rd = rd; w.rw = 0; w.m2r = 0; w.mis = 0;
        if (go) begin
            r.addr = alu - (alu % 4);
            r.we   = mw;
            if (is_byte(f3)) begin
                r.be = 4'(1 << (alu % 4));
                r.wdata = {24'h0, sd[7:0]} * 32'h0101_0101;
            end else if (is_half(f3)) begin
                r.be = (alu % 4 >= 2) ? 4'b1100 : 4'b0011;
                r.wdata = {16'h0, sd[15:0]} * 32'h0001_0001;
            end else begin
                r.be = 4'b1111;
                r.wdata = sd;
            end
            req_q.push_back(r);
            resp_q.push_back('{delay, rdata});
            if (!mw) begin
                w.rw = rw; w.m2r = 1; w.mem_data = load_model(f3, alu, rdata);
                wb_q.push_back(w);
            end
        end else if (mis) begin
            w.mis = 1;
            wb_q.push_back(w);
        end else if (v && rw) begin
            w.rw = 1;
            wb_q.push_back(w);
        end
        exp_stall = go ? 1 + delay : 0;

        ex_valid = v; alu_result = alu; store_data = sd; ex_rd_addr = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 60) begin
                fail("stall_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("stall_cycles", stalls, exp_stall);
    endtask

    // ---------------- memory responder ----------------
    resp_t cur;
    bit    busy = 0;
    initial begin
        dmem_ack = 0;
        dmem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                // directed phases drive ack themselves
            end else if (dmem_req) begin
                if (!busy) begin
                    if (resp_q.size() == 0) begin
                        fail("unexpected_dmem_req");
                        cur = '{0, 32'h0};
                    end else begin
                        cur = resp_q.pop_front();
                    end
                    busy = 1;
                end
                if (cur.delay == 0) begin
                    dmem_ack = 1; dmem_rdata = cur.rdata;
                end else begin
                    cur.delay--; dmem_ack = 0; dmem_rdata = $urandom;
                end
            end else begin
                busy = 0;
                dmem_ack = ($urandom_range(0, 4) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    bit   req_prev = 0;
    req_t last_req;
    req_t mr_t;
    wb_t  mw_t;
    always @(negedge clk) begin
        if (mon_en) begin
            if (dmem_req && !req_prev) begin
                if (req_q.size() == 0) fail("req_no_expectation");
                else begin
                    mr_t = req_q.pop_front();
                    chk("req_addr", dmem_addr, mr_t.addr);
                    chk("req_we", {31'h0, dmem_we}, {31'h0, mr_t.we});
                    chk("req_be", {28'h0, dmem_be}, {28'h0, mr_t.be});
                    chk("req_wdata", dmem_wdata, mr_t.wdata);
                    last_req = mr_t;
                end
            end else if (dmem_req) begin
                chk("req_hold_addr", dmem_addr, last_req.addr);
                chk("req_hold_be", {28'h0, dmem_be}, {28'h0, last_req.be});
            end
            if (wb_reg_write || wb_mem_to_reg || mem_misalign) begin
                if (wb_q.size() == 0) begin
                    $display("FAIL wb_unexpected rw=%b m2r=%b mis=%b alu=%h", wb_reg_write,
                             wb_mem_to_reg, mem_misalign, wb_alu_data);
                    checks++; errors++;
                end else begin
                    mw_t = wb_q.pop_front();
                    chk("wb_flags", {29'h0, wb_reg_write, wb_mem_to_reg, mem_misalign},
                        {29'h0, mw_t.rw, mw_t.m2r, mw_t.mis});
                    if (!mw_t.mis) begin
                        chk("wb_alu_data", wb_alu_data, mw_t.alu);
                        chk("wb_rd_addr", {27'h0, wb_rd_addr}, {27'h0, mw_t.rd});
                    end
                    if (mw_t.m2r) chk("wb_mem_data", wb_mem_data, mw_t.mem_data);
                end
            end
        end
        req_prev = dmem_req;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        rst = 1;
        ex_valid = 1; alu_result = 32'h0000_0040; store_data = 0; ex_rd_addr = 5'd1;
        ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wb_mem", wb_mem_data, 32'h0);
        chk("rst_wb_alu", wb_alu_data, 32'h0);
        chk("rst_wb_rd", {27'h0, wb_rd_addr}, 32'h0);
        chk("rst_wb_flags", {29'h0, wb_reg_write, wb_mem_to_reg, mem_misalign}, 32'h0);

        // Reset while a request is outstanding, then a late ack in IDLE
        rst = 0;
        @(negedge clk);
        chk("idle_load_stall", {31'h0, mem_stall}, 32'h1);
        @(posedge clk); #1;
        chk("req_raised", {31'h0, dmem_req}, 32'h1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; ex_valid = 0; dmem_ack = 1;
        chk("req_dropped", {31'h0, dmem_req}, 32'h0);
        chk("late_ack_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        dmem_ack = 0;
        chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
        chk("late_ack_wb", {30'h0, wb_reg_write, wb_mem_to_reg}, 32'h0);
        @(posedge clk); #1;
        chk("late_ack_still_idle", {31'h0, dmem_req}, 32'h0);

        resp_en = 1;
        mon_en  = 1;

        // Directed cases
        issue(1, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 3'b000, 0, 32'h0);           // ADD
        issue(1, 32'h0000_0103, 32'h0, 5'd7, 1, 1, 0, 3'b000, 3, 32'h80FF_FF7F);   // LB
        issue(1, 32'h0000_0103, 32'h0, 5'd8, 1, 1, 0, 3'b100, 3, 32'h80FF_FF7F);   // LBU
        issue(1, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 1, 0, 1, 3'b001, 1, 32'h0);   // SH
        issue(1, 32'h0000_0006, 32'h0, 5'd3, 1, 1, 0, 3'b010, 0, 32'h1357_9BDF);   // LW
        issue(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000, 0, 32'h0);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            int          kind;
            bit          v, mr, mw;
            logic [2:0]  f3;
            kind = $urandom_range(0, 9);
            v  = (kind != 0);
            mr = 0; mw = 0;
            f3 = 3'($urandom);
            if (kind == 0) begin
                mr = 1'($urandom); mw = 1'($urandom);
            end else if (kind <= 3) begin
                mr = 1; f3 = ld_f3[$urandom_range(0, 4)];
            end else if (kind <= 5) begin
                mw = 1; f3 = st_f3[$urandom_range(0, 2)];
            end else if (kind == 6) begin
                mr = 1; mw = 1; f3 = st_f3[$urandom_range(0, 2)];
            end
            issue(v, $urandom, $urandom, 5'($urandom), 1'($urandom), mr, mw, f3,
                  $urandom_range(0, 4), $urandom);
        end

        // Drain
        for (int i = 0; i < 4; i++) issue(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000, 0, 32'h0);
        chk("drain_wb_q", wb_q.size(), 32'h0);
        chk("drain_req_q", req_q.size(), 32'h0);
        chk("drain_resp_q", resp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit reached");
    end

endmodule

`default_nettype wire
